iter_shift_left: RTL and testbench
==================================

ITER_SHIFT_LEFT -- requirements
Module: iter_shift_left

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width (WIDTH = 2**SHW).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  WIDTH  operand.
REQ-008 SHALL have port shift  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 SHALL have port op  input  1  0 = logical left, 1 = rotate left.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port q  output  WIDTH  shifted result.
REQ-013 SHALL have port carry  output  1  last bit shifted out.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 SHALL accept a request on an edge with in_valid && in_ready, capturing a, shift, op; carry working value cleared to 0.
REQ-016 SHALL, on accept with shift == 0, go IDLE -> DONE with q = a, carry = 0.
REQ-017 SHALL, on accept with shift != 0, go IDLE -> BUSY with remaining = shift.
REQ-018 SHALL, per BUSY edge, shift working word left by 4 if remaining >= 4, else by 1; remaining decremented by the step size.
REQ-019 SHALL, for op = 0, fill vacated LSBs with 0; carry = last bit shifted out of the MSB in that step.
REQ-020 SHALL, for op = 1, wrap bits out of the MSB into the LSBs; carry = bit 0 of the resulting word.
REQ-021 SHALL go BUSY -> DONE on the edge where remaining becomes 0; number of BUSY edges = floor(shift/4) + (shift mod 4).
REQ-022 SHALL hold q and carry stable in DONE until out_ready is sampled high, then go DONE -> IDLE.
REQ-023 SHALL ignore in_valid outside IDLE, with captured operands unaffected; no same-edge accept-and-retire.
REQ-024 SHALL treat inputs a/shift/op as don't-care except on the accept edge.
REQ-025 SHALL produce result bit-exact to (a << shift) for op = 0 and a rotated left by shift for op = 1, modulo WIDTH.

Reset
REQ-026 SHALL, with reset high at an edge, force state = IDLE, q = 0, carry = 0, remaining = 0, out_valid = 0, in_ready = 1 after the edge.
REQ-027 SHALL abort any BUSY or DONE transaction on reset with no result delivered; reset overrides a simultaneous in_valid.

Verification
REQ-028 SHALL cover: op = 0, a = F000DEAD, shift = 0 -> DONE after accept edge, q = F000DEAD, carry = 0.
REQ-029 SHALL cover: op = 0, a = F000DEAD, shift = 1 -> 1 BUSY edge, q = E001BD5A, carry = 1; shift = 4 -> 1 BUSY edge, q = 000DEAD0, carry = 1.
REQ-030 SHALL cover: op = 0, a = F000DEAD, shift = 31 -> 10 BUSY edges, q = 80000000, carry = 0.
REQ-031 SHALL cover: op = 1, a = F000DEAD, shift = 8 -> 2 BUSY edges, q = 00DEADF0, carry = 0; shift = 17 -> 5 BUSY edges, q = BD5BE001, carry = 1.
REQ-032 SHALL cover: out_ready held low 5 cycles in DONE, new in_valid pulsed -> q/carry stable, in_ready = 0, second request not accepted; retire on out_ready = 1, then accept.
REQ-033 SHALL cover: reset asserted during BUSY of shift = 31 -> IDLE next edge, out_valid = 0, q = 0; next request completes correctly.

Source files
------------

// File: rtl/iter_shift_left.sv
// Multi-cycle left shifter/rotator. Shifts by 4 per cycle while at least 4 positions
// remain, then by 1, so a full shift takes floor(shift/4) + shift%4 busy cycles.
module iter_shift_left #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   shift,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic             carry
);

   // state | meaning
   // IDLE  | waiting for a request, in_ready high
   // BUSY  | stepping the working word, remaining > 0
   // DONE  | result held on q/carry until out_ready
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [SHW-1:0] STEP4 = SHW'(4);
   localparam logic [SHW-1:0] STEP1 = SHW'(1);

   state_t         state;
   logic [SHW-1:0] remaining;
   logic           op_r;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         q         <= '0;
         carry     <= 1'b0;
         remaining <= '0;
         op_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  q         <= a;
                  carry     <= 1'b0;
                  op_r      <= op;
                  remaining <= shift;
                  state     <= (shift == '0) ? DONE : BUSY;
               end
            end
            BUSY: begin
               // For both ops the carry ends up as the last bit leaving the MSB,
               // since a rotate deposits exactly that bit into bit 0.
               if (remaining >= STEP4) begin
                  q         <= op_r ? {q[WIDTH-5:0], q[WIDTH-1:WIDTH-4]}
                                    : {q[WIDTH-5:0], 4'b0000};
                  carry     <= q[WIDTH-4];
                  remaining <= remaining - STEP4;
                  if (remaining == STEP4)
                     state <= DONE;
               end else begin
                  q         <= op_r ? {q[WIDTH-2:0], q[WIDTH-1]}
                                    : {q[WIDTH-2:0], 1'b0};
                  carry     <= q[WIDTH-1];
                  remaining <= remaining - STEP1;
                  if (remaining == STEP1)
                     state <= DONE;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_shift_left.sv
// Directed bench for iter_shift_left: hand-computed shift/rotate results, busy-cycle
// counts, DONE back-pressure and reset abort.
module tb_iter_shift_left;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [4:0]  shift;
   logic        op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] q;
   logic        carry;

   int checks = 0;
   int errors = 0;

   iter_shift_left #(.WIDTH(32), .SHW(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .shift     (shift),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .carry     (carry)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request and wait (bounded) for DONE; returns busy-edge count.
   task automatic start_and_wait(input logic [31:0] av, input logic [4:0] sv,
                                 input logic ov, output int busy);
      @(negedge clk);
      in_valid = 1'b1;
      a        = av;
      shift    = sv;
      op       = ov;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a        = 32'h5A5A_5A5A;
      shift    = 5'd7;
      op       = ~ov;
      busy     = 0;
      while (!out_valid && busy < 64) begin
         @(negedge clk);
         busy++;
      end
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("in_ready_after_retire", 32'(in_ready), 32'd1);
   endtask

   task automatic run_vec(input string tag, input logic [31:0] av, input logic [4:0] sv,
                          input logic ov, input logic [31:0] exp_q, input logic exp_c,
                          input int exp_busy);
      int busy;
      start_and_wait(av, sv, ov, busy);
      check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_q"}, q, exp_q);
      check({tag, "_carry"}, 32'(carry), 32'(exp_c));
      retire();
   endtask

   initial begin
      int busy;
      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      shift     = '0;
      op        = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_q", q, 32'h0);
      check("rst_carry", 32'(carry), 32'd0);
      reset = 1'b0;

      run_vec("lsl0",  32'hF000_DEAD, 5'd0,  1'b0, 32'hF000_DEAD, 1'b0, 0);
      run_vec("lsl1",  32'hF000_DEAD, 5'd1,  1'b0, 32'hE001_BD5A, 1'b1, 1);
      run_vec("lsl4",  32'hF000_DEAD, 5'd4,  1'b0, 32'h000D_EAD0, 1'b1, 1);
      run_vec("lsl5",  32'hF000_DEAD, 5'd5,  1'b0, 32'h001B_D5A0, 1'b0, 2);
      run_vec("lsl31", 32'hF000_DEAD, 5'd31, 1'b0, 32'h8000_0000, 1'b0, 10);
      run_vec("rol8",  32'hF000_DEAD, 5'd8,  1'b1, 32'h00DE_ADF0, 1'b0, 2);
      run_vec("rol17", 32'hF000_DEAD, 5'd17, 1'b1, 32'hBD5B_E001, 1'b1, 5);
      run_vec("rol31", 32'hF000_DEAD, 5'd31, 1'b1, 32'hF800_6F56, 1'b0, 10);

      // Back-pressure in DONE with a competing request pulsed mid-wait.
      start_and_wait(32'hF000_DEAD, 5'd4, 1'b0, busy);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            in_valid = 1'b1;
            a        = 32'h1234_5678;
            shift    = 5'd0;
            op       = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         check("hold_q", q, 32'h000D_EAD0);
         check("hold_carry", 32'(carry), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      retire();
      run_vec("after_hold", 32'h0000_0001, 5'd3, 1'b0, 32'h0000_0008, 1'b0, 3);

      // Reset during BUSY of a long shift, with in_valid also high.
      @(negedge clk);
      in_valid = 1'b1;
      a        = 32'hF000_DEAD;
      shift    = 5'd31;
      op       = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_before_rst", 32'(in_ready), 32'd0);
      reset    = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset    = 1'b0;
      in_valid = 1'b0;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_q", q, 32'h0);
      check("abort_carry", 32'(carry), 32'd0);
      @(negedge clk);
      check("abort_no_accept", 32'(in_ready), 32'd1);
      run_vec("post_rst", 32'hF000_DEAD, 5'd31, 1'b0, 32'h8000_0000, 1'b0, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
